spi_rx_sequencer: RTL and testbench

SPI_RX_SEQUENCER -- requirements
Module: spi_rx_sequencer

---
 rtl/spi_rx_sequencer_if.sv | 33 +++
 rtl/spi_rx_sequencer.sv | 138 +++++++++++++
 tb/tb_spi_rx_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_rx_sequencer_if : handshake/bus bundle between the SPI RX sequencer,  |
// | its external shifter and the word consumer.                               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface spi_rx_sequencer_if #(
    parameter int BUS_WIDTH   = 8,
    parameter int COUNTER_REG = $clog2(BUS_WIDTH)
);
    logic                   cs_n;
    logic                   sample_tick;
    logic                   shift_en;
    logic [BUS_WIDTH-1:0]   shift_q;
    logic [BUS_WIDTH-1:0]   rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [COUNTER_REG-1:0] bit_cnt;
    logic                   frame_err;
    logic                   overrun;
    logic                   ovr_clr;

    modport slave (
        input  cs_n, sample_tick, shift_q, rx_ready, ovr_clr,
        output shift_en, rx_data, rx_valid, bit_cnt, frame_err, overrun
    );

    modport master (
        output cs_n, sample_tick, shift_q, rx_ready, ovr_clr,
        input  shift_en, rx_data, rx_valid, bit_cnt, frame_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/spi_rx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_rx_sequencer : bit counter / word loader for an external SPI shifter. |
// | Optional macro SPI_RX_OVERRUN_EN: drop words into a full holding register.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_rx_sequencer #(
    parameter int BUS_WIDTH   = 8,
    parameter int COUNTER_REG = $clog2(BUS_WIDTH)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    spi_rx_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_LOAD   = 2'd2
    } state_t;

    localparam logic [COUNTER_REG-1:0] c_LAST_BIT = COUNTER_REG'(BUS_WIDTH - 1);
    localparam logic [COUNTER_REG-1:0] c_ONE      = COUNTER_REG'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COUNTER_REG-1:0] r_bit_cnt;
    logic [COUNTER_REG-1:0] w_bit_cnt_nxt;
    logic [BUS_WIDTH-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_frame_err_nxt;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_drop;

    assign w_shift = bus.sample_tick & ~bus.cs_n;

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_frame_err_nxt = 1'b0;
        w_load          = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_bit_cnt_nxt = '0;
                if (!bus.cs_n) begin
                    w_state_nxt = S_ACTIVE;
                    if (w_shift) w_bit_cnt_nxt = c_ONE;
                end
            end
            S_ACTIVE: begin
                if (bus.cs_n) begin
                    w_state_nxt     = S_IDLE;
                    w_bit_cnt_nxt   = '0;
                    w_frame_err_nxt = (r_bit_cnt != '0);
                end else if (w_shift) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_LOAD;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_ONE;
                    end
                end
            end
            S_LOAD: begin
                // The shifter already holds the full word; a tick here starts the next one.
                w_load = 1'b1;
                if (bus.cs_n) begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_state_nxt   = S_ACTIVE;
                    w_bit_cnt_nxt = w_shift ? c_ONE : '0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

`ifdef SPI_RX_OVERRUN_EN
    assign w_drop = w_load & r_rx_valid & ~bus.rx_ready;
`else
    logic w_unused_ovr_clr;
    assign w_drop           = 1'b0;
    assign w_unused_ovr_clr = bus.ovr_clr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // A load in the same cycle as a consume keeps rx_valid high.
            if (w_load && !w_drop) begin
                r_rx_data  <= bus.shift_q;
                r_rx_valid <= 1'b1;
            end else if (!w_load && r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
`ifdef SPI_RX_OVERRUN_EN
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
`else
            r_overrun <= 1'b0;
`endif
        end
    end

    assign bus.shift_en  = w_shift;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.bit_cnt   = r_bit_cnt;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_rx_sequencer : directed + random bench with a bit-level word model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_spi_rx_sequencer;
    localparam int BW = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    logic sdata;
    logic [BW-1:0] r_sh = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: words are just groups of BW ticks taken while cs_n is low.
    int            m_cnt;
    logic [BW-1:0] m_acc;
    logic [BW-1:0] m_word;
    bit            m_cap;
    logic [BW-1:0] m_data;
    bit            m_valid;
    bit            m_ferr;
    bit            m_ovr;

    always #5 clk = ~clk;

    spi_rx_sequencer_if #(.BUS_WIDTH(BW), .COUNTER_REG(CW)) bus ();

    spi_rx_sequencer #(.BUS_WIDTH(BW), .COUNTER_REG(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) if (bus.shift_en) r_sh <= {r_sh[BW-2:0], sdata};
    assign bus.shift_q = r_sh;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_cap = 0; m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_acc = '0; m_word = '0;
    endtask

    task automatic model_step(input bit cs, input bit tick, input bit b, input bit rdy, input bit clr);
        bit ovr_set;
        ovr_set = 0;
        if (m_cap) begin
            if (m_valid && !rdy) begin
`ifdef SPI_RX_OVERRUN_EN
                ovr_set = 1;
`else
                m_data = m_word;
`endif
            end else begin
                m_data  = m_word;
                m_valid = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
`ifdef SPI_RX_OVERRUN_EN
        if (ovr_set) m_ovr = 1;
        else if (clr) m_ovr = 0;
`else
        m_ovr = 0;
`endif
        m_cap  = 0;
        m_ferr = 0;
        if (cs) begin
            m_ferr = (m_cnt != 0);
            m_cnt  = 0;
        end else if (tick) begin
            m_acc = {m_acc[BW-2:0], b};
            m_cnt++;
            if (m_cnt == BW) begin
                m_cnt  = 0;
                m_word = m_acc;
                m_cap  = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rx_data"},   32'(bus.rx_data),   32'(m_data));
        chk({tag, ".rx_valid"},  32'(bus.rx_valid),  32'(m_valid));
        chk({tag, ".bit_cnt"},   32'(bus.bit_cnt),   32'(m_cnt));
        chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
        chk({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc(input bit cs, input bit tick, input bit b, input bit rdy, input bit clr);
        bus.cs_n = cs; bus.sample_tick = tick; sdata = b; bus.rx_ready = rdy; bus.ovr_clr = clr;
        #1;
        chk("shift_en", 32'(bus.shift_en), 32'(tick & ~cs));
        @(posedge clk);
        model_step(cs, tick, b, rdy, clr);
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic send_word(input logic [BW-1:0] w, input bit rdy);
        logic [BW-1:0] v;
        v = w;
        for (int i = BW - 1; i >= 0; i--) cyc(1'b0, 1'b1, v[i], rdy, 1'b0);
    endtask

    task automatic mid_reset();
        bus.cs_n = 1'b1; bus.sample_tick = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst.rx_data",   32'(bus.rx_data),   32'h0);
        chk("rst.rx_valid",  32'(bus.rx_valid),  32'h0);
        chk("rst.bit_cnt",   32'(bus.bit_cnt),   32'h0);
        chk("rst.frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst.overrun",   32'(bus.overrun),   32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.cs_n = 1'b1; bus.sample_tick = 1'b0; bus.rx_ready = 1'b0; bus.ovr_clr = 1'b0; sdata = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        mid_reset();

        // Single word A5, consumer stalled.
        send_word(8'hA5, 1'b0);
        chk("a5.not_yet_valid", 32'(bus.rx_valid), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5.data",    32'(bus.rx_data),  32'hA5);
        chk("a5.valid",   32'(bus.rx_valid), 32'h1);
        chk("a5.bit_cnt", 32'(bus.bit_cnt),  32'h0);

        // Consume.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("consume.valid", 32'(bus.rx_valid), 32'h0);
        chk("consume.data",  32'(bus.rx_data),  32'hA5);

        // Partial word then deselect.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ferr.pulse",   32'(bus.frame_err), 32'h1);
        chk("ferr.bit_cnt", 32'(bus.bit_cnt),   32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ferr.one_cycle", 32'(bus.frame_err), 32'h0);

        // Second word while the first is still pending.
        send_word(8'h3C, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SPI_RX_OVERRUN_EN
        chk("ovr.data", 32'(bus.rx_data), 32'h3C);
        chk("ovr.flag", 32'(bus.overrun), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr.clr",  32'(bus.overrun), 32'h0);
`else
        chk("ovr.data", 32'(bus.rx_data), 32'hC3);
        chk("ovr.flag", 32'(bus.overrun), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr.clr",  32'(bus.overrun), 32'h0);
`endif

        // Back-to-back words with a tick in the LOAD cycle, consumer always ready.
        send_word(8'h96, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b2b.bit_cnt", 32'(bus.bit_cnt),  32'h1);
        chk("b2b.data",    32'(bus.rx_data),  32'h96);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'(i % 2), 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b.data2",   32'(bus.rx_data),  32'hAA);
        chk("b2b.valid2",  32'(bus.rx_valid), 32'h1);

        // Reset mid-word with a word pending, then a fresh word.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst.bit_cnt", 32'(bus.bit_cnt), 32'h5);
        mid_reset();
        send_word(8'h5A, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst.data",  32'(bus.rx_data),  32'h5A);
        chk("post_rst.valid", 32'(bus.rx_valid), 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
